sparse_vec_loader: RTL and testbench

Byte-to-vector assembler that sits directly downstream of the comm unit's UART receiver. While `load_data` is high it collects a 32-byte host stream (A values, A indices, B values, B indices; each field 8 bytes, least-significant byte first) into shadow registers. After the last byte it commits all four 64-bit operand vectors to the multiplier datapath in a single cycle. An inter-byte watchdog and an abort path ensure a partially received load never reaches the outputs.

---
 rtl/comm_pkg.sv | 34 +++
 rtl/inter_byte_watchdog.sv | 31 +++
 rtl/sparse_vec_loader.sv | 143 ++++++++++++++
 tb/tb_sparse_vec_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the host operand loader
package comm_pkg;

  localparam int DEF_ELEM_W    = 16;
  localparam int DEF_NUM_ELEMS = 4;
  localparam int FIELD_BYTES   = DEF_ELEM_W * DEF_NUM_ELEMS / 8;

  typedef enum logic [2:0] {
    IDLE,
    A_VAL,
    A_IDX,
    B_VAL,
    B_IDX,
    COMMIT
  } loader_state_t;

  // Shadow-array slot for a field state; A_VAL..B_IDX map to 0..3.
  function automatic logic [1:0] field_of(loader_state_t s);
    logic [2:0] d;
    d = 3'(s) - 3'd1;
    return d[1:0];
  endfunction

  function automatic loader_state_t field_after(loader_state_t s);
    case (s)
      A_VAL:   return A_IDX;
      A_IDX:   return B_VAL;
      B_VAL:   return B_IDX;
      B_IDX:   return COMMIT;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/inter_byte_watchdog.sv
// rtl/inter_byte_watchdog.sv - idle-cycle counter between accepted bytes
// expired is asserted combinationally during the TIMEOUT_CYCLES-th idle cycle.
module inter_byte_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != SAT) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sparse_vec_loader.sv
// rtl/sparse_vec_loader.sv - assembles a 32-byte host stream into four operand vectors
// Bytes land in shadow registers; outputs change only in the single COMMIT cycle.
module sparse_vec_loader
  import comm_pkg::*;
#(
  parameter int ELEM_W         = DEF_ELEM_W,
  parameter int NUM_ELEMS      = DEF_NUM_ELEMS,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_data,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [ELEM_W*NUM_ELEMS-1:0]   a_val,
  output logic [ELEM_W*NUM_ELEMS-1:0]   a_idx,
  output logic [ELEM_W*NUM_ELEMS-1:0]   b_val,
  output logic [ELEM_W*NUM_ELEMS-1:0]   b_idx,
  output logic                          vec_valid,
  output logic                          done,
  output logic                          busy,
  output logic                          err
);

  localparam int FIELD_W = ELEM_W * NUM_ELEMS;
  localparam int BYTES   = FIELD_W / 8;
  localparam int BC_W    = $clog2(BYTES);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  loader_state_t     state, state_n;
  logic [BC_W-1:0]   byte_cnt, cnt_n, wr_byte;
  logic [1:0]        wr_field;
  logic              wr_en, start, do_commit, err_n;
  logic              in_field, wd_expired;
  logic [FIELD_W-1:0] shadow [4];

  assign in_field = (state == A_VAL) || (state == A_IDX) ||
                    (state == B_VAL) || (state == B_IDX);
  assign busy     = (state != IDLE);

  inter_byte_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid),
    .enable  (in_field),
    .expired (wd_expired)
  );

  // Priority inside a field: abort, then byte accept, then timeout.
  always_comb begin
    state_n   = state;
    cnt_n     = byte_cnt;
    wr_en     = 1'b0;
    wr_field  = 2'd0;
    wr_byte   = byte_cnt;
    start     = 1'b0;
    do_commit = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        wr_byte = '0;
        if (load_data && rx_valid) begin
          wr_en   = 1'b1;
          start   = 1'b1;
          cnt_n   = BC_W'(1);
          state_n = A_VAL;
        end
      end
      A_VAL, A_IDX, B_VAL, B_IDX: begin
        if (!load_data) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (rx_valid) begin
          wr_en    = 1'b1;
          wr_field = field_of(state);
          if (byte_cnt == LAST_BYTE) begin
            cnt_n   = '0;
            state_n = field_after(state);
          end else begin
            cnt_n = byte_cnt + BC_W'(1);
          end
        end else if (wd_expired) begin
          state_n = IDLE;
          cnt_n   = '0;
          err_n   = 1'b1;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        err_n     = rx_valid;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      byte_cnt <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow[wr_field][8*wr_byte +: 8] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_val     <= '0;
      a_idx     <= '0;
      b_val     <= '0;
      b_idx     <= '0;
      vec_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= do_commit;
      err  <= err_n;
      if (start) begin
        vec_valid <= 1'b0;
      end
      if (do_commit) begin
        a_val     <= shadow[0];
        a_idx     <= shadow[1];
        b_val     <= shadow[2];
        b_idx     <= shadow[3];
        vec_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sparse_vec_loader.sv
// tb/tb_sparse_vec_loader.sv - randomized bench with a byte-stream reference model
module tb_sparse_vec_loader;
  import comm_pkg::*;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_data = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [63:0] a_val, a_idx, b_val, b_idx;
  logic        vec_valid, done, busy, err;

  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;
  int exp_err = 0;

  logic [63:0] exp_vec [4];
  logic        exp_vv;
  logic [7:0]  lb [32];

  sparse_vec_loader #(
    .ELEM_W(16), .NUM_ELEMS(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .load_data(load_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .a_val(a_val), .a_idx(a_idx), .b_val(b_val),
    .b_idx(b_idx), .vec_valid(vec_valid), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_seen++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] field_val(int f);
    logic [63:0] v = '0;
    for (int k = 0; k < FIELD_BYTES; k++) v = v | (64'(lb[FIELD_BYTES*f + k]) << (8*k));
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_a_val"}, a_val, exp_vec[0]);
    chk({tag, "_a_idx"}, a_idx, exp_vec[1]);
    chk({tag, "_b_val"}, b_val, exp_vec[2]);
    chk({tag, "_b_idx"}, b_idx, exp_vec[3]);
    chk({tag, "_vec_valid"}, vec_valid, exp_vv);
    chk({tag, "_err_count"}, err_seen, exp_err);
  endtask

  task automatic randomize_bytes();
    for (int i = 0; i < 32; i++) lb[i] = 8'($urandom);
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, 3)) tick();
      rx_valid = 1'b1;
      rx_data  = lb[i];
      tick();
      rx_valid = 1'b0;
      if (i == 0) exp_vv = 1'b0;
    end
  endtask

  // stall_idx: idle TO-1 cycles before that byte so it lands on the expiry cycle.
  task automatic full_load(input int stall_idx, input bit overrun);
    load_data = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == stall_idx) repeat (TO - 1) tick();
      else if (i > 0) repeat ($urandom_range(0, 3)) tick();
      rx_valid = 1'b1;
      rx_data  = lb[i];
      tick();
      rx_valid = 1'b0;
      if (i == 0) begin
        exp_vv = 1'b0;
        chk("load_busy_start", busy, 1);
        chk("load_vv_cleared", vec_valid, 0);
      end
    end
    chk("done_early", done, 0);
    chk("busy_in_commit", busy, 1);
    if (overrun) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      exp_err++;
    end
    tick();
    rx_valid = 1'b0;
    for (int f = 0; f < 4; f++) exp_vec[f] = field_val(f);
    exp_vv = 1'b1;
    chk("done_pulse", done, 1);
    chk("overrun_err", err, overrun);
    tick();
    load_data = 1'b0;
    chk("done_single", done, 0);
    chk("busy_after_commit", busy, 0);
    check_outputs("commit");
  endtask

  initial begin
    for (int f = 0; f < 4; f++) exp_vec[f] = '0;
    exp_vv = 1'b0;

    repeat (3) tick();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    check_outputs("reset");
    reset = 1'b1;
    tick();

    load_data = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      tick();
      rx_valid = 1'b0;
      chk("idle_busy", busy, 0);
    end
    check_outputs("idle_ignore");

    for (int i = 0; i < 8; i++) begin
      lb[i]      = 8'hFF;
      lb[16 + i] = 8'hEE;
    end
    for (int i = 0; i < 8; i++) begin
      lb[8 + i]  = (i % 2 == 0) ? 8'(3 - i / 2) : 8'h00;
      lb[24 + i] = lb[8 + i];
    end
    full_load(-1, 1'b0);
    chk("dir_a_val", a_val, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dir_a_idx", a_idx, 64'h0000_0001_0002_0003);
    chk("dir_b_val", b_val, 64'hEEEE_EEEE_EEEE_EEEE);
    chk("dir_b_idx", b_idx, 64'h0000_0001_0002_0003);

    randomize_bytes();
    load_data = 1'b1;
    send_bytes(12);
    load_data = 1'b0;
    rx_valid  = 1'b1;
    tick();
    rx_valid  = 1'b0;
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_busy_hold", busy, 0);
    check_outputs("abort");

    randomize_bytes();
    full_load(-1, 1'b0);

    randomize_bytes();
    load_data = 1'b1;
    send_bytes(5);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO - 1) begin
        chk("to_err_before", err, 0);
        chk("to_busy_before", busy, 1);
      end
      if (k == TO) begin
        chk("to_err_pulse", err, 1);
        chk("to_busy_after", busy, 0);
      end
    end
    exp_err++;
    tick();
    chk("to_err_single", err, 0);
    load_data = 1'b0;
    check_outputs("timeout");

    randomize_bytes();
    full_load(5, 1'b0);

    randomize_bytes();
    full_load(-1, 1'b1);

    randomize_bytes();
    load_data = 1'b1;
    send_bytes(21);
    reset = 1'b0;
    load_data = 1'b0;
    #1;
    for (int f = 0; f < 4; f++) exp_vec[f] = '0;
    exp_vv = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    check_outputs("midrst");
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int r = 0; r < 5; r++) begin
      randomize_bytes();
      full_load(-1, r == 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
